// File: rtl/spi_register_interface.sv
// SPI mode-0 slave turning 32-bit write frames into register write strobes.
// All SPI pins are oversampled in the i_Clock domain; MISO echoes the last register number.
`timescale 1ns/1ps
module spi_register_interface #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_SPI_SCK,
  input  logic                  i_SPI_MOSI,
  input  logic                  i_SPI_CS_n,
  output logic                  o_SPI_MISO,
  output logic [ADDR_WIDTH-1:0] o_RegisterNumber,
  output logic [DATA_WIDTH-1:0] o_RegisterValue,
  output logic                  o_RegisterWriteEnable,
  output logic                  o_FrameError
);

  localparam int FW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(FW + 1);
  localparam logic [CW-1:0] LAST = CW'(FW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sck_prev_q, cs_prev_q;

  logic [FW-1:0]         shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] echo_q, echo_d;
  logic [ADDR_WIDTH-1:0] miso_sr_q, miso_sr_d;
  logic                  miso_q, miso_d;
  logic [ADDR_WIDTH-1:0] num_q, num_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;

  logic sck_s, mosi_s, cs_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic last_bit, take_bit, abort;

  assign sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_SPI_SCK};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS_n};

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  // The final bit wins over a coincident CS_n rise; any earlier bit loses.
  assign last_bit = sck_rise & (cnt_q == LAST);
  assign take_bit = sck_rise & (last_bit | ~cs_rise);
  assign abort    = cs_rise & ~last_bit;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      shift_q     <= '0;
      cnt_q       <= '0;
      echo_q      <= '0;
      miso_sr_q   <= '0;
      miso_q      <= 1'b0;
      num_q       <= '0;
      val_q       <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      echo_q      <= echo_d;
      miso_sr_q   <= miso_sr_d;
      miso_q      <= miso_d;
      num_q       <= num_d;
      val_q       <= val_d;
      we_q        <= we_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (cs_fall) state_d = SHIFT;
      SHIFT: begin
        if (last_bit)   state_d = COMMIT;
        else if (abort) state_d = IDLE;
      end
      COMMIT: state_d = WAIT;
      WAIT:   if (cs_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    echo_d    = echo_q;
    miso_sr_d = miso_sr_q;
    miso_d    = miso_q;
    num_d     = num_q;
    val_d     = val_q;
    we_d      = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          cnt_d     = '0;
          miso_sr_d = echo_q;
          miso_d    = echo_q[ADDR_WIDTH-1];
        end
      end
      SHIFT: begin
        if (take_bit) begin
          shift_d = {shift_q[FW-2:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
        end else if (abort) begin
          if (cnt_q != '0) err_d = 1'b1;
          miso_d = 1'b0;
        end else if (sck_fall) begin
          miso_sr_d = {miso_sr_q[ADDR_WIDTH-2:0], 1'b0};
          miso_d    = miso_sr_q[ADDR_WIDTH-2];
        end
      end
      COMMIT: begin
        num_d  = shift_q[FW-1:DATA_WIDTH];
        val_d  = shift_q[DATA_WIDTH-1:0];
        we_d   = 1'b1;
        echo_d = shift_q[FW-1:DATA_WIDTH];
        err_d  = 1'b0;
      end
      WAIT: if (cs_s) miso_d = 1'b0;
      default: ;
    endcase
  end

  assign o_SPI_MISO            = miso_q;
  assign o_RegisterNumber      = num_q;
  assign o_RegisterValue       = val_q;
  assign o_RegisterWriteEnable = we_q;
  assign o_FrameError          = err_q;

endmodule

// File: tb/tb_spi_register_interface.sv
// Scoreboard bench for spi_register_interface: directed SPI frames,
// expected commits queued at issue time and matched by a strobe monitor.
`timescale 1ns/1ps
module tb_spi_register_interface;

  logic        clk;
  logic        rst_n;
  logic        sck;
  logic        mosi;
  logic        cs_n;
  logic        miso;
  logic [15:0] num;
  logic [15:0] val;
  logic        we;
  logic        err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int strobes = 0;

  logic [31:0] sb[$];
  logic [31:0] mbits;

  spi_register_interface #(
    .SYNC_STAGES(2),
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16)
  ) dut (
    .i_Clock(clk),
    .i_Reset_n(rst_n),
    .i_SPI_SCK(sck),
    .i_SPI_MOSI(mosi),
    .i_SPI_CS_n(cs_n),
    .o_SPI_MISO(miso),
    .o_RegisterNumber(num),
    .o_RegisterValue(val),
    .o_RegisterWriteEnable(we),
    .o_FrameError(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      logic [31:0] e;
      strobes++;
      if (sb.size() == 0) begin
        check("unexpected_strobe", {num, val}, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        check("commit_num", {16'h0, num}, {16'h0, e[31:16]});
        check("commit_val", {16'h0, val}, {16'h0, e[15:0]});
        check("commit_err", {31'h0, err}, 32'h0);
      end
    end
  end

  // SCK period 160 ns against a 10 ns i_Clock; edges land on negedge clk.
  task automatic spi_xfer(input logic [63:0] data,
                          input int nbits,
                          input bit keep_cs,
                          output logic [31:0] mb);
    mb = '0;
    @(negedge clk);
    cs_n = 1'b0;
    #160;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[nbits-1-i];
      #80;
      mb = {mb[30:0], miso};
      sck = 1'b1;
      #80;
      sck = 1'b0;
    end
    if (!keep_cs) begin
      #160;
      cs_n = 1'b1;
      mosi = 1'b0;
      #320;
    end
  endtask

  task automatic frame(input logic [31:0] data);
    sb.push_back(data);
    spi_xfer({32'h0, data}, 32, 1'b0, mbits);
  endtask

  initial begin
    rst_n = 1'b0;
    sck   = 1'b0;
    mosi  = 1'b0;
    cs_n  = 1'b1;
    #23;
    check("rst_num", {16'h0, num}, 32'h0);
    check("rst_val", {16'h0, val}, 32'h0);
    check("rst_we", {31'h0, we}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_miso", {31'h0, miso}, 32'h0);
    rst_n = 1'b1;
    #40;

    frame(32'h1200_ABCD);
    check("single_err", {31'h0, err}, 32'h0);
    check("single_hold", {num, val}, 32'h1200_ABCD);

    spi_xfer(64'h23000, 20, 1'b0, mbits);
    check("abort_err", {31'h0, err}, 32'h1);
    check("abort_hold", {num, val}, 32'h1200_ABCD);

    frame(32'h1001_0001);
    check("recover_err", {31'h0, err}, 32'h0);

    frame(32'h1200_ABCD);
    frame(32'h0000_0000);
    check("echo_hi", {16'h0, mbits[31:16]}, 32'h1200);
    check("echo_lo", {16'h0, mbits[15:0]}, 32'h0);

    frame(32'hBEEF_0000);
    frame(32'h0000_0001);
    check("echo2_hi", {16'h0, mbits[31:16]}, 32'hBEEF);

    sb.push_back(32'h3400_5555);
    spi_xfer(64'h34_0055_55FF, 40, 1'b0, mbits);
    check("overlong_val", {16'h0, val}, 32'h5555);
    check("overlong_err", {31'h0, err}, 32'h0);

    frame(32'hAAAA_0001);
    frame(32'h5555_0002);
    check("b2b_last", {num, val}, 32'h5555_0002);

    spi_xfer(64'h1_FFFF, 17, 1'b1, mbits);
    rst_n = 1'b0;
    #1;
    check("midrst_num", {16'h0, num}, 32'h0);
    check("midrst_val", {16'h0, val}, 32'h0);
    check("midrst_we", {31'h0, we}, 32'h0);
    check("midrst_miso", {31'h0, miso}, 32'h0);
    #40;
    cs_n = 1'b1;
    sck  = 1'b0;
    #40;
    rst_n = 1'b1;
    #40;

    frame(32'h0101_0042);
    check("post_rst", {num, val}, 32'h0101_0042);
    frame(32'h0000_0000);
    check("post_rst_echo", {16'h0, mbits[31:16]}, 32'h0101);

    #200;
    check("sb_drained", sb.size(), 32'h0);
    check("strobe_count", strobes, 32'd11);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_register_interface.md
Name: spi_register_interface

Overview:
- SPI slave that turns 32-bit serial write frames from the host MCU into single-cycle register writes for the synth register file.
- Drives the synth's i_RegisterNumber, i_RegisterValue and i_RegisterWriteEnable inputs. Sits directly upstream of synth.
- SPI pins are asynchronous to i_Clock. They are oversampled through synchronizers; no SCK-clocked logic.
- MISO echoes the last committed register number so the host can verify the link.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (SCK, MOSI, CS_n); minimum 2.
- ADDR_WIDTH, 16, register number width.
- DATA_WIDTH, 16, register value width. Frame length is ADDR_WIDTH+DATA_WIDTH (32).

Ports:
- i_Clock  in  1  system clock, rising edge.
- i_Reset_n  in  1  asynchronous active-low reset.
- i_SPI_SCK  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), async.
- i_SPI_MOSI  in  1  serial data in, MSB first, async.
- i_SPI_CS_n  in  1  chip select, active low, async.
- o_SPI_MISO  out  1  serial data out, echo of last committed register number.
- o_RegisterNumber  out  ADDR_WIDTH  register number of committed write.
- o_RegisterValue  out  DATA_WIDTH  value of committed write.
- o_RegisterWriteEnable  out  1  one-cycle write strobe.
- o_FrameError  out  1  sticky: frame aborted with 1..31 bits; cleared by the next good commit.

Behaviour:
- Clocking and reset (already decided): one clock, i_Clock. Reset i_Reset_n is asynchronous, active-low.
- Reset values:
  - all outputs 0; o_SPI_MISO 0.
  - shift register, bit counter and echo register 0.
  - synchronizer chains preset so that CS_n=1 and SCK=0.
  - state IDLE.
- Synchronization and edge detection:
  - SCK, MOSI and CS_n each pass through SYNC_STAGES flops; a sampled copy of the synced SCK and CS_n gives edge detection.
  - Requirement: i_Clock >= 8x SCK frequency.
- States:
  - IDLE: wait for synced CS_n falling edge.
    - On it: clear the bit counter, load the echo register into the MISO shift register, drive its MSB onto MISO. Go to SHIFT.
  - SHIFT, on synced SCK rising edge: shift the synced MOSI into the LSB of the 32-bit shift register and increment the counter.
    - When the counter reaches 32, go to COMMIT.
  - SHIFT, on synced SCK falling edge: advance the MISO shift register and present the next bit.
    - After 16 bits MISO outputs 0.
  - SHIFT, on synced CS_n rising edge with counter 1..31: set o_FrameError and go to IDLE. No write.
    - CS_n rising with counter 0: go to IDLE silently.
  - COMMIT, one cycle:
    - o_RegisterNumber = shift[31:16]; o_RegisterValue = shift[15:0].
    - o_RegisterWriteEnable = 1 for exactly this cycle.
    - Echo register = shift[31:16]; o_FrameError cleared. Go to WAIT.
  - WAIT: ignore SCK edges (bits beyond 32 are discarded); on synced CS_n rising, go to IDLE.
- Latency: the strobe is asserted exactly 2 i_Clock cycles after the cycle in which the synced SCK rise of bit 32 is first visible. That is SYNC_STAGES+2 cycles after the raw SCK edge, ±1 for metastability resolution.
- o_RegisterNumber/o_RegisterValue hold their value until the next commit; they never change outside COMMIT.
- Simultaneous events:
  - CS_n rising in the same cycle as the SCK rise of bit 32: the bit is taken and the commit proceeds, then IDLE.
  - CS_n rising in the same cycle as the SCK rise of bit ≤31: abort wins; the bit is dropped and o_FrameError is set.
- Back-to-back frames: CS_n falling while in WAIT is not possible without a prior rise. A new frame may start in the cycle after the return to IDLE.
- While CS_n is high: SCK and MOSI activity is ignored; MISO is driven 0 (no tristate).
- Reset mid-frame: immediate return to reset values. No strobe, no partial commit.

Test Plan:
- Single write: CS_n low, 32 bits 0x1200_ABCD, CS_n high -> exactly one strobe pulse; o_RegisterNumber=0x1200, o_RegisterValue=0xABCD; o_FrameError=0.
- Echo: after the previous frame, send 0x0000_0000 -> MISO bits during SCK 1..16 read 0x1200, then 0 for bits 17..32.
- Abort: CS_n high after 20 bits of 0x2300_0001 -> no strobe; outputs still 0x1200/0xABCD; o_FrameError=1. Next good frame 0x1001_0001 -> strobe, error cleared.
- Overlong frame: 40 SCK pulses carrying 0x3400_5555 then 0xFF -> one strobe, value 0x5555; trailing bits ignored.
- Back-to-back: two frames with CS_n high for 2 SCK periods between them -> two strobes with the correct values, in order.
- Async reset asserted at bit 17 -> all outputs 0 immediately. After release, a full frame 0x0101_0042 commits normally.
